weight_rom_sequencer: RTL and testbench

WEIGHT_ROM_SEQUENCER -- requirements
Module: weight_rom_sequencer

---
 rtl/weight_rom_sequencer.sv | 156 +++++++++++++++
 tb/tb_weight_rom_sequencer.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/weight_rom_sequencer.sv
// Streams MEM_SIZE ROM words per pass into a FIFO through a 2-entry skid buffer.
// Define WEIGHT_SEQ_MULTIPASS_EN to honour n_passes; otherwise exactly one pass runs.
module weight_rom_sequencer #(
    parameter int MEM_SIZE   = 9,
    parameter int DATA_WIDTH = 16
) (
    input  logic                        ap_clk,
    input  logic                        ap_rst_n,
    input  logic                        ap_start,
    input  logic [15:0]                 n_passes,
    output logic                        ap_idle,
    output logic                        ap_done,
    output logic [$clog2(MEM_SIZE)-1:0] weight_V_address0,
    output logic                        weight_V_ce0,
    input  logic [DATA_WIDTH-1:0]       weight_V_q0,
    output logic [DATA_WIDTH-1:0]       output_V_din,
    input  logic                        output_V_full_n,
    output logic                        output_V_write,
    output logic [1:0]                  o_dbg_state
);

    localparam int AW = $clog2(MEM_SIZE);
    localparam logic [AW-1:0] LAST_ADDR = AW'(MEM_SIZE - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [AW-1:0]           r_addr;
    logic [15:0]             r_pass;
    logic [15:0]             r_num_passes;
    logic                    r_inflight;
    logic [1:0]              r_count;
    logic [DATA_WIDTH-1:0]   r_head;
    logic [DATA_WIDTH-1:0]   r_tail;

    logic                    w_start;
    logic                    w_pop;
    logic                    w_push;
    logic                    w_issue;
    logic                    w_last_pass;
    logic                    w_last_read;
    logic                    w_last_pop;
    logic [2:0]              w_occ;
    logic [15:0]             w_passes_eff;

`ifdef WEIGHT_SEQ_MULTIPASS_EN
    assign w_passes_eff = (n_passes == 16'd0) ? 16'd1 : n_passes;
`else
    logic w_unused_passes;
    assign w_unused_passes = ^n_passes;
    assign w_passes_eff    = 16'd1;
`endif

    assign w_start     = (r_state == S_IDLE) && ap_start;
    assign w_pop       = (r_count != 2'd0) && output_V_full_n;
    assign w_push      = r_inflight;
    // Buffer slots already spoken for after this edge: held words plus the read landing now.
    assign w_occ       = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_last_pass = (r_pass == r_num_passes - 16'd1);
    assign w_last_read = w_issue && (r_addr == LAST_ADDR) && w_last_pass;
    assign w_last_pop  = w_pop && (r_count == 2'd1) && !r_inflight;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (ap_start)    w_state_nxt = S_RUN;
            S_RUN:   if (w_last_read) w_state_nxt = S_DRAIN;
            S_DRAIN: if (w_last_pop)  w_state_nxt = S_DONE;
            S_DONE:                   w_state_nxt = S_IDLE;
            default:                  w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        ap_idle = (r_state == S_IDLE);
        ap_done = (r_state == S_DONE);
        w_issue = (r_state == S_RUN) && (w_occ < 3'd2);
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_addr       <= '0;
            r_pass       <= 16'd0;
            r_num_passes <= 16'd1;
            r_inflight   <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (w_start) begin
                r_addr       <= '0;
                r_pass       <= 16'd0;
                r_num_passes <= w_passes_eff;
            end else if (w_issue) begin
                if (r_addr == LAST_ADDR) begin
                    r_addr <= '0;
                    r_pass <= r_pass + 16'd1;
                end else begin
                    r_addr <= r_addr + 1'b1;
                end
            end
        end
    end

    // Head is always the oldest word, so din comes straight from a flop.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_count <= 2'd0;
            r_head  <= '0;
            r_tail  <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_head <= weight_V_q0;
                    end else begin
                        r_tail <= weight_V_q0;
                    end
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_head  <= r_tail;
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    if (r_count == 2'd1) begin
                        r_head <= weight_V_q0;
                    end else begin
                        r_head <= r_tail;
                        r_tail <= weight_V_q0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign weight_V_ce0      = w_issue;
    assign weight_V_address0 = r_addr;
    assign output_V_write    = (r_count != 2'd0);
    assign output_V_din      = r_head;
    assign o_dbg_state       = r_state;

endmodule

// File: tb/tb_weight_rom_sequencer.sv
// Bench for weight_rom_sequencer: ROM model, full_n driver, per-cycle scoreboard monitor.
module tb_weight_rom_sequencer;

    localparam int MEM = 9;
    localparam int DW  = 16;
    localparam int AW  = $clog2(MEM);
`ifdef WEIGHT_SEQ_MULTIPASS_EN
    localparam int EXP3 = 27;
`else
    localparam int EXP3 = 9;
`endif

    logic          ap_clk = 1'b0;
    logic          ap_rst_n;
    logic          ap_start;
    logic [15:0]   n_passes;
    logic          ap_idle;
    logic          ap_done;
    logic [AW-1:0] weight_V_address0;
    logic          weight_V_ce0;
    logic [DW-1:0] weight_V_q0 = '0;
    logic [DW-1:0] output_V_din;
    logic          output_V_full_n = 1'b1;
    logic          output_V_write;
    logic [1:0]    dbg_state;

    weight_rom_sequencer #(.MEM_SIZE(MEM), .DATA_WIDTH(DW)) dut (
        .ap_clk            (ap_clk),
        .ap_rst_n          (ap_rst_n),
        .ap_start          (ap_start),
        .n_passes          (n_passes),
        .ap_idle           (ap_idle),
        .ap_done           (ap_done),
        .weight_V_address0 (weight_V_address0),
        .weight_V_ce0      (weight_V_ce0),
        .weight_V_q0       (weight_V_q0),
        .output_V_din      (output_V_din),
        .output_V_full_n   (output_V_full_n),
        .output_V_write    (output_V_write),
        .o_dbg_state       (dbg_state)
    );

    always #5 ap_clk = ~ap_clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [DW-1:0] rom [0:MEM-1];
    logic [DW-1:0] exp_q[$];

    int            cyc = 0;
    bit            m_idle = 1'b1;
    bit            m_done_due = 1'b0;
    bit            m_nostall = 1'b0;
    int            issued = 0;
    int            accepted = 0;
    int            total_words = 0;
    int            exp_addr = 0;
    int            first_write_cyc = 0;
    int            first_write_seen = -1;
    int            start_cyc = 0;
    int            start_gap = 0;
    int            words_this_run = 0;
    int            starts = 0;
    int            runs_done = 0;
    int            dut_done_cnt = 0;
    int            dut_done_cyc = -100;
    int            last_accept_cyc = 0;
    logic [DW-1:0] first_din = '0;
    logic [DW-1:0] last_din = '0;
    bit            prev_stall = 1'b0;
    logic [DW-1:0] prev_din = '0;
    int            fn_mode = 0;
    int            ph = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int passes_for(input logic [15:0] np);
`ifdef WEIGHT_SEQ_MULTIPASS_EN
        return (np == 16'd0) ? 1 : int'(np);
`else
        return (np == 16'd0) ? 1 : 1;
`endif
    endfunction

    // Synchronous ROM: data appears the cycle after ce0.
    always @(posedge ap_clk) begin
        if (weight_V_ce0) begin
            if (int'(weight_V_address0) < MEM) weight_V_q0 <= rom[int'(weight_V_address0)];
            else weight_V_q0 <= 16'hdead;
        end
    end

    always @(negedge ap_clk) begin
        ph++;
        case (fn_mode)
            0:       output_V_full_n = 1'b1;
            1:       output_V_full_n = ((ph % 4) == 0) || ((ph % 4) == 3);
            2:       output_V_full_n = ($urandom_range(0, 3) != 0);
            default: output_V_full_n = ($urandom_range(0, 1) == 1);
        endcase
    end

    always @(negedge ap_clk) begin : monitor
        bit was_idle;
        bit was_done;
        bit busy;
        bit pop;
        bit emptied;
        int outst;
        int np;
        #2;
        cyc++;
        emptied = 1'b0;
        if (!ap_rst_n) begin
            chk("rst_idle", 32'(ap_idle), 32'd1);
            chk("rst_done", 32'(ap_done), 32'd0);
            chk("rst_ce0", 32'(weight_V_ce0), 32'd0);
            chk("rst_write", 32'(output_V_write), 32'd0);
            chk("rst_addr", 32'(weight_V_address0), 32'd0);
            exp_q.delete();
            m_idle = 1'b1; m_done_due = 1'b0; prev_stall = 1'b0;
            issued = 0; accepted = 0; exp_addr = 0;
        end else begin
            was_idle = m_idle;
            was_done = m_done_due;
            busy     = !was_idle && !was_done;
            pop      = output_V_write && output_V_full_n;
            chk("ap_idle", 32'(ap_idle), 32'(was_idle));
            chk("ap_done", 32'(ap_done), 32'(was_done));
            if (ap_done) begin
                dut_done_cnt++;
                dut_done_cyc = cyc;
            end
            if (exp_q.size() == 0) chk("no_write", 32'(output_V_write), 32'd0);
            else if (output_V_write) chk("din", 32'(output_V_din), 32'(exp_q[0]));
            if (prev_stall) begin
                chk("write_held", 32'(output_V_write), 32'd1);
                chk("din_stable", 32'(output_V_din), 32'(prev_din));
            end
            if (busy && cyc < first_write_cyc) chk("early_write", 32'(output_V_write), 32'd0);
            if (busy && cyc == first_write_cyc) chk("first_write_latency", 32'(output_V_write), 32'd1);
            if (busy && m_nostall && exp_q.size() != 0 && cyc > first_write_cyc)
                chk("back_to_back", 32'(output_V_write), 32'd1);
            if (busy && output_V_write && first_write_seen < 0) first_write_seen = cyc;
            outst = issued - accepted;
            if (!busy) begin
                chk("ce0_quiet", 32'(weight_V_ce0), 32'd0);
            end else begin
                chk("outstanding_le2", 32'(outst <= 2), 32'd1);
                if (weight_V_ce0) begin
                    chk("rd_addr", 32'(weight_V_address0), 32'(exp_addr));
                    chk("rd_budget", 32'((outst - int'(pop)) < 2), 32'd1);
                    chk("rd_count", 32'(issued < total_words), 32'd1);
                    issued++;
                    exp_addr = (exp_addr + 1) % MEM;
                end
            end
            if (pop && exp_q.size() != 0) begin
                if (words_this_run == 0) first_din = output_V_din;
                last_din        = output_V_din;
                last_accept_cyc = cyc;
                words_this_run++;
                accepted++;
                void'(exp_q.pop_front());
                emptied = (exp_q.size() == 0);
            end
            prev_stall = output_V_write && !output_V_full_n;
            prev_din   = output_V_din;
            if (was_done) begin
                m_done_due = 1'b0;
                m_idle     = 1'b1;
                runs_done++;
            end else if (emptied && busy) begin
                m_done_due = 1'b1;
            end
            if (was_idle && ap_start) begin
                np              = passes_for(n_passes);
                start_cyc       = cyc;
                start_gap       = cyc - dut_done_cyc;
                total_words     = np * MEM;
                first_write_cyc = cyc + 3;
                first_write_seen = -1;
                issued = 0; accepted = 0; exp_addr = 0; words_this_run = 0;
                m_nostall = (fn_mode == 0);
                for (int p = 0; p < np; p++)
                    for (int a = 0; a < MEM; a++) exp_q.push_back(rom[a]);
                m_idle = 1'b0;
                starts++;
            end
        end
    end

    task automatic wait_model_idle();
        int i = 0;
        while (!(m_idle && !m_done_due) && i < 500) begin
            @(negedge ap_clk);
            i++;
        end
        chk("idle_wait_timeout", 32'(m_idle), 32'd1);
    endtask

    task automatic start_run(input logic [15:0] np);
        wait_model_idle();
        @(negedge ap_clk);
        n_passes = np;
        ap_start = 1'b1;
        @(negedge ap_clk);
        ap_start = 1'b0;
    endtask

    task automatic wait_run_done(input int limit);
        int target = runs_done + 1;
        int i = 0;
        while (runs_done < target && i < limit) begin
            @(negedge ap_clk);
            i++;
        end
        chk("run_timeout", 32'(runs_done >= target), 32'd1);
    endtask

    task automatic load_rom(input bit rnd);
        for (int a = 0; a < MEM; a++) rom[a] = rnd ? 16'($urandom()) : 16'(16'h0100 + a);
    endtask

    initial begin
        int d0;
        int s0;
        int i;
        ap_rst_n = 1'b0;
        ap_start = 1'b0;
        n_passes = 16'd0;
        load_rom(1'b0);
        repeat (3) @(negedge ap_clk);
        chk("rst_dbg_state", 32'(dbg_state), 32'd0);
        ap_rst_n = 1'b1;
        repeat (2) @(negedge ap_clk);

        // Single pass, no back-pressure.
        start_run(16'd1);
        wait_run_done(200);
        chk("t1_latency", 32'(first_write_seen - start_cyc), 32'd3);
        chk("t1_words", 32'(words_this_run), 32'd9);
        chk("t1_first", 32'(first_din), 32'h100);
        chk("t1_last", 32'(last_din), 32'h108);
        chk("t1_done_gap", 32'(dut_done_cyc - last_accept_cyc), 32'd1);

        // Three passes, one ap_done.
        d0 = dut_done_cnt;
        start_run(16'd3);
        wait_run_done(300);
        chk("t2_words", 32'(words_this_run), 32'(EXP3));
        chk("t2_done_pulses", 32'(dut_done_cnt - d0), 32'd1);
        chk("t2_last", 32'(last_din), 32'h108);

        // full_n 1,0,0,1 pattern.
        fn_mode = 1;
        start_run(16'd1);
        wait_run_done(300);
        chk("t3_words", 32'(words_this_run), 32'd9);
        chk("t3_last", 32'(last_din), 32'h108);
        fn_mode = 0;

        // Reset pulse after the fourth accepted word.
        start_run(16'd1);
        i = 0;
        while (words_this_run < 4 && i < 200) begin
            @(negedge ap_clk);
            i++;
        end
        chk("t4_reached_4", 32'(words_this_run), 32'd4);
        ap_rst_n = 1'b0;
        #1;
        chk("t4_write_now", 32'(output_V_write), 32'd0);
        chk("t4_ce0_now", 32'(weight_V_ce0), 32'd0);
        chk("t4_idle_now", 32'(ap_idle), 32'd1);
        chk("t4_done_now", 32'(ap_done), 32'd0);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        repeat (6) @(negedge ap_clk);
        start_run(16'd1);
        wait_run_done(200);
        chk("t4_first", 32'(first_din), 32'h100);
        chk("t4_words", 32'(words_this_run), 32'd9);

        // ap_start pulsed mid-run, then held through DONE.
        start_run(16'd1);
        s0 = starts;
        repeat (3) @(negedge ap_clk);
        ap_start = 1'b1;
        @(negedge ap_clk);
        ap_start = 1'b0;
        repeat (3) @(negedge ap_clk);
        ap_start = 1'b1;
        i = 0;
        while (starts < s0 + 1 && i < 200) begin
            @(negedge ap_clk);
            i++;
        end
        ap_start = 1'b0;
        chk("t5_restart", 32'(starts), 32'(s0 + 1));
        chk("t5_restart_gap", 32'(start_gap), 32'd1);
        wait_run_done(200);
        chk("t5_words", 32'(words_this_run), 32'd9);

        // n_passes = 0 behaves as 1.
        start_run(16'd0);
        wait_run_done(200);
        chk("t6_words", 32'(words_this_run), 32'd9);
        chk("t6_first", 32'(first_din), 32'h100);

        // Randomized runs.
        for (int r = 0; r < 12; r++) begin
            wait_model_idle();
            fn_mode = $urandom_range(0, 3);
            load_rom(1'b1);
            start_run(16'($urandom_range(0, 3)));
            wait_run_done(600);
            chk("rand_words", 32'(words_this_run), 32'(total_words));
            repeat ($urandom_range(0, 3)) @(negedge ap_clk);
        end

        fn_mode = 0;
        repeat (5) @(negedge ap_clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, errors so far %0d", n_errors);
        $fatal(1, "watchdog expired");
    end

endmodule
